hex_display_ctrl: RTL and testbench



---
 rtl/hex_display_pkg.sv | 36 +++
 rtl/hex_display_ctrl_tick_prescaler.sv | 35 +++
 rtl/hex_display_ctrl.sv | 149 ++++++++++++++
 tb/tb_hex_display_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types, register map and reset constants for the six-digit hex display controller.
package hex_display_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  enable;
    } ctrl_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_MSG    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [5:0]  SEG_BLANK_ALL  = 6'h3F;
    localparam logic [5:0]  SEG_BLANK_NONE = 6'h00;
    localparam logic [23:0] DATA_RST       = 24'h000000;
    localparam logic [31:0] MSG_RST        = 32'h0000_0000;
    localparam ctrl_t       CTRL_RST       = '{mode: MODE_STATIC, enable: 1'b0};

    // The reserved mode code is displayed exactly like static.
    function automatic mode_e eff_mode(input mode_e m);
        return (m == MODE_RSVD) ? MODE_STATIC : m;
    endfunction

    function automatic logic [31:0] rot_nibble_left(input logic [31:0] v);
        return {v[27:0], v[31:28]};
    endfunction

endpackage

// File: rtl/hex_display_ctrl_tick_prescaler.sv
// Free-running display-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_prescaler #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int                 CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (clr || (cnt_reg == CNT_MAX)) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // A restart request also swallows a wrap landing in the same cycle.
    assign tick = (cnt_reg == CNT_MAX) && !clr;

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM controlled six-digit hex display with static, blink and scroll modes.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [23:0] seg_data,
    output logic [5:0]  seg_blank
);

    ctrl_t       ctrl_reg;
    logic [23:0] data_reg;
    logic [31:0] msg_reg;
    logic [31:0] rot_reg;
    logic [2:0]  pos_reg;
    logic        phase_reg;
    logic [31:0] readdata_reg;
    logic [31:0] readdata_next;
    logic [23:0] seg_data_reg;
    logic [23:0] seg_data_next;
    logic [5:0]  seg_blank_reg;
    logic [5:0]  seg_blank_next;

    logic  wr_data;
    logic  wr_ctrl;
    logic  wr_msg;
    logic  any_wr;
    logic  tick_raw;
    logic  tick_eff;
    mode_e mode_sel;
    mode_e wr_mode;
    logic  digit_dark;
    logic [23:0] src_data;

    assign wr_data  = avs_write && (avs_address == ADDR_DATA);
    assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    assign wr_msg   = avs_write && (avs_address == ADDR_MSG);
    assign any_wr   = wr_data || wr_ctrl || wr_msg;
    assign wr_mode  = mode_e'(avs_writedata[2:1]);
    assign mode_sel = eff_mode(ctrl_reg.mode);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .clr   (wr_ctrl),
        .tick  (tick_raw)
    );

    // Any register write in the tick cycle takes priority; that tick is lost.
    assign tick_eff = tick_raw && !any_wr;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_reg <= DATA_RST;
            ctrl_reg <= CTRL_RST;
            msg_reg  <= MSG_RST;
        end else begin
            if (wr_data) begin
                data_reg <= avs_writedata[23:0];
            end
            if (wr_ctrl) begin
                ctrl_reg <= '{mode: wr_mode, enable: avs_writedata[0]};
            end
            if (wr_msg) begin
                msg_reg <= avs_writedata;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rot_reg   <= MSG_RST;
            pos_reg   <= 3'd0;
            phase_reg <= 1'b0;
        end else begin
            if (wr_msg) begin
                rot_reg <= avs_writedata;
                pos_reg <= 3'd0;
            end else if (wr_ctrl && (eff_mode(wr_mode) == MODE_SCROLL)) begin
                rot_reg <= msg_reg;
                pos_reg <= 3'd0;
            end else if (tick_eff && (mode_sel == MODE_SCROLL)) begin
                rot_reg <= rot_nibble_left(rot_reg);
                pos_reg <= pos_reg + 3'd1;
            end

            if (wr_ctrl && (wr_mode == MODE_BLINK)) begin
                phase_reg <= 1'b0;
            end else if (tick_eff && (mode_sel == MODE_BLINK)) begin
                phase_reg <= !phase_reg;
            end
        end
    end

    // Data keeps following the mode source even while the display is disabled.
    assign src_data   = (mode_sel == MODE_SCROLL) ? rot_reg[31:8] : data_reg;
    assign digit_dark = !ctrl_reg.enable || ((mode_sel == MODE_BLINK) && phase_reg);

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            assign seg_data_next[gi*4 +: 4] = src_data[gi*4 +: 4];
            assign seg_blank_next[gi]       = digit_dark;
        end
    endgenerate

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            seg_data_reg  <= DATA_RST;
            seg_blank_reg <= SEG_BLANK_ALL;
        end else begin
            seg_data_reg  <= seg_data_next;
            seg_blank_reg <= seg_blank_next;
        end
    end

    always_comb begin
        readdata_next = 32'h0;
        unique case (avs_address)
            ADDR_DATA:   readdata_next = {8'h00, data_reg};
            ADDR_CTRL:   readdata_next = {29'h0, ctrl_reg};
            ADDR_MSG:    readdata_next = msg_reg;
            ADDR_STATUS: readdata_next = {28'h0, pos_reg, phase_reg};
            default:     readdata_next = 32'h0;
        endcase
    end

    // Captured from pre-edge state, so a same-cycle write is not visible yet.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_reg <= 32'h0;
        end else if (avs_read) begin
            readdata_reg <= readdata_next;
        end
    end

    assign avs_readdata = readdata_reg;
    assign seg_data     = seg_data_reg;
    assign seg_blank    = seg_blank_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl with TICK_DIV = 4: stimulus queues expectations, a monitor checks them.
module tb_hex_display_ctrl;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [23:0] seg_data;
    logic [5:0]  seg_blank;

    hex_display_ctrl #(.TICK_DIV(4)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .seg_data      (seg_data),
        .seg_blank     (seg_blank)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    typedef struct {
        int          cyc;
        logic [23:0] data;
        logic [5:0]  blank;
        bit          chk_rd;
        string       name;
    } disp_t;

    typedef struct {
        logic [31:0] val;
        logic [31:0] mask;
        string       name;
    } rd_t;

    disp_t disp_q[$];
    rd_t   rd_q[$];
    int    cyc = 0;
    bit    rd_seen = 1'b0;
    int    n_checks = 0;
    int    n_pass = 0;

    logic [23:0] scroll_tbl [8] = '{24'h123456, 24'h234567, 24'h345678, 24'h456781,
                                    24'h567812, 24'h678123, 24'h781234, 24'h812345};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk_clk) begin
        cyc     <= cyc + 1;
        rd_seen <= avs_read && reset_reset_n;
    end

    always @(negedge clk_clk) begin
        while (disp_q.size() > 0 && disp_q[0].cyc < cyc) begin
            disp_t e;
            e = disp_q.pop_front();
            check({"stale_", e.name}, cyc, e.cyc);
        end
        while (disp_q.size() > 0 && disp_q[0].cyc == cyc) begin
            disp_t e;
            e = disp_q.pop_front();
            check({e.name, "_data"}, {8'h0, seg_data}, {8'h0, e.data});
            check({e.name, "_blank"}, {26'h0, seg_blank}, {26'h0, e.blank});
            if (e.chk_rd) check({e.name, "_readdata"}, avs_readdata, 32'h0);
        end
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check("unexpected_read", avs_readdata, 32'hxxxx_xxxx);
            end else begin
                rd_t r;
                r = rd_q.pop_front();
                check(r.name, avs_readdata & r.mask, r.val & r.mask);
                $display("read  %-14s data=%h", r.name, avs_readdata);
            end
        end
    end

    task automatic push_disp(input int c, input logic [23:0] d, input logic [5:0] b, input string name);
        disp_t e;
        e.cyc = c; e.data = d; e.blank = b; e.chk_rd = 1'b0; e.name = name;
        disp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk_clk);
        avs_write = 1'b0;
        $display("write addr=%0d data=%h (edge %0d)", a, d, cyc);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] v, input logic [31:0] m, input string name);
        rd_t r;
        r.val = v; r.mask = m; r.name = name;
        rd_q.push_back(r);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0;
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] v, input string name);
        rd_t r;
        r.val = v; r.mask = 32'hFFFF_FFFF; r.name = name;
        rd_q.push_back(r);
        avs_address = a; avs_writedata = d; avs_read = 1'b1; avs_write = 1'b1;
        @(negedge clk_clk);
        avs_read = 1'b0; avs_write = 1'b0;
        $display("write addr=%0d data=%h with read (edge %0d)", a, d, cyc);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, got cycle %0d required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int b;
        int s;
        int r;
        avs_address = 2'd0; avs_write = 1'b0; avs_writedata = 32'h0; avs_read = 1'b0;
        reset_reset_n = 1'b0;
        idle(3);
        reset_reset_n = 1'b1;

        // Reset state
        c = cyc;
        push_disp(c + 1, 24'h0, 6'h3F, "reset_c1");
        push_disp(c + 2, 24'h0, 6'h3F, "reset_c2");
        rd(2'd3, 32'h0, 32'hFFFF_FFFF, "reset_status");
        rd(2'd1, 32'h0, 32'hFFFF_FFFF, "reset_ctrl");

        // Static: data tracks while disabled, then becomes visible the edge after CTRL
        wr(2'd0, 32'h00DA_BEEF);
        push_disp(cyc + 1, 24'hDABEEF, 6'h3F, "static_disabled");
        wr(2'd1, 32'h1);
        c = cyc;
        for (int i = 1; i <= 20; i++) push_disp(c + i, 24'hDABEEF, 6'h00, $sformatf("static_%0d", i));
        idle(20);
        rd(2'd0, 32'h00DA_BEEF, 32'hFFFF_FFFF, "data_readback");
        rd(2'd1, 32'h1, 32'hFFFF_FFFF, "ctrl_readback");

        // Same-address read and write returns the old value; upper DATA bits read zero
        c = cyc;
        push_disp(c + 1, 24'hDABEEF, 6'h00, "rdwr_before");
        push_disp(c + 2, 24'h0FF1CE, 6'h00, "rdwr_after");
        rdwr(2'd0, 32'hFF0F_F1CE, 32'h00DA_BEEF, "rdwr_old_value");
        rd(2'd0, 32'h000F_F1CE, 32'hFFFF_FFFF, "data_upper_zero");

        // Reserved mode behaves as static: no blinking across two tick periods
        wr(2'd1, 32'h7);
        r = cyc;
        for (int i = 1; i <= 10; i++) push_disp(r + i, 24'h0FF1CE, 6'h00, $sformatf("rsvd_%0d", i));
        rd(2'd1, 32'h7, 32'hFFFF_FFFF, "ctrl_rsvd");
        idle(9);

        // Blink: visible for 4 cycles, dark for 4, first change 4 ticks-cycles after the write edge
        wr(2'd1, 32'h3);
        b = cyc;
        for (int i = 1; i <= 20; i++)
            push_disp(b + i, 24'h0FF1CE, (((i - 1) / 4) % 2 == 1) ? 6'h3F : 6'h00, $sformatf("blink_%0d", i));
        idle(13);
        rd(2'd3, 32'h1, 32'hFFFF_FFFF, "blink_phase");
        idle(6);

        // Scroll: one nibble step per tick, full wrap after 8 ticks
        wr(2'd2, 32'h1234_5678);
        wr(2'd1, 32'h5);
        s = cyc;
        for (int i = 1; i <= 36; i++)
            push_disp(s + i, scroll_tbl[((i - 1) / 4) % 8], 6'h00, $sformatf("scroll_%0d", i));
        idle(29);
        rd(2'd3, 32'hE, 32'hE, "scroll_pos7");
        idle(3);
        rd(2'd3, 32'h0, 32'hE, "scroll_pos_wrap");
        idle(2);

        // MSG write landing on a tick edge: tick dropped, reload, next step 4 cycles later
        for (int i = 37; i <= 40; i++) push_disp(s + i, 24'h234567, 6'h00, $sformatf("pre_reload_%0d", i));
        for (int i = 41; i <= 44; i++) push_disp(s + i, 24'hA1B2C3, 6'h00, $sformatf("reload_%0d", i));
        for (int i = 45; i <= 48; i++) push_disp(s + i, 24'h1B2C3D, 6'h00, $sformatf("reload_step_%0d", i));
        idle(3);
        wr(2'd2, 32'hA1B2_C3D4);
        rd(2'd3, 32'h0, 32'hE, "reload_pos0");
        idle(6);
        rd(2'd2, 32'hA1B2_C3D4, 32'hFFFF_FFFF, "msg_readback");

        // Asynchronous reset between edges mid-scroll
        @(posedge clk_clk);
        #2;
        reset_reset_n = 1'b0;
        begin
            disp_t e;
            e.cyc = cyc; e.data = 24'h0; e.blank = 6'h3F; e.chk_rd = 1'b1; e.name = "async_reset";
            disp_q.push_back(e);
        end
        $display("reset asserted between edges (cycle %0d)", cyc);
        idle(2);
        reset_reset_n = 1'b1;
        c = cyc;
        for (int i = 1; i <= 8; i++) push_disp(c + i, 24'h0, 6'h3F, $sformatf("post_reset_%0d", i));
        rd(2'd1, 32'h0, 32'hFFFF_FFFF, "post_reset_ctrl");
        rd(2'd2, 32'h0, 32'hFFFF_FFFF, "post_reset_msg");
        rd(2'd3, 32'h0, 32'hFFFF_FFFF, "post_reset_status");
        idle(7);

        check("disp_queue_drained", disp_q.size(), 0);
        check("read_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
